// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter in front of one shared 16-bit barrel shifter
//
// Modules:
//   barrel_shifter : combinational shifter; mode 00 SLL, 01 SRA, 1x ROR.
//   shift_arbiter  : top level; grants one of two valid/ready requesters,
//                    drives the shared shifter, registers the result.
//
// shift_arbiter ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req0_valid/ready/data/amt/mode   execute-stage request channel
//   req1_valid/ready/data/amt/mode   bit-manipulation-unit request channel
//   rsp_valid/ready              one-entry result register handshake
//   rsp_data, rsp_id             shifted result and winning requester ID
//
// Build option:
//   SHIFT_ARB_RR_EN defined   : round-robin on contention (winner != last)
//   SHIFT_ARB_RR_EN undefined : fixed priority, requester 0 wins contention

module barrel_shifter #(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (mode)
            2'b00:   result = data << amt;
            2'b01:   result = WIDTH'($signed(data) >>> amt);
            // Rotate right: shift the doubled word and keep the low half.
            default: result = WIDTH'({data, data} >> amt);
        endcase
    end

endmodule

module shift_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [WIDTH-1:0]         req0_data,
    input  logic [$clog2(WIDTH)-1:0] req0_amt,
    input  logic [1:0]               req0_mode,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [WIDTH-1:0]         req1_data,
    input  logic [$clog2(WIDTH)-1:0] req1_amt,
    input  logic [1:0]               req1_mode,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_id
);

    localparam int AW = $clog2(WIDTH);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             pick0;
    logic [1:0]       grant;
    logic             can_accept;
    logic             xfer0;
    logic             xfer1;
    logic             any_xfer;
    logic [WIDTH-1:0] sh_data;
    logic [AW-1:0]    sh_amt;
    logic [1:0]       sh_mode;
    logic [WIDTH-1:0] sh_result;

    // Contention policy: pick0 says whether requester 0 wins when both are valid.
`ifdef SHIFT_ARB_RR_EN
    assign pick0 = last;
`else
    logic unused_last;
    assign pick0       = 1'b1;
    assign unused_last = last;
`endif

    assign grant[0] = req0_valid & (~req1_valid | pick0);
    assign grant[1] = req1_valid & (~req0_valid | ~pick0);

    // Result register drains in the same cycle it refills.
    assign can_accept = ~rsp_valid | rsp_ready;

    // Readies are forced low while reset is held, even though the register is empty.
    assign req0_ready = grant[0] & can_accept & rst_n;
    assign req1_ready = grant[1] & can_accept & rst_n;

    assign xfer0    = req0_valid & req0_ready;
    assign xfer1    = req1_valid & req1_ready;
    assign any_xfer = xfer0 | xfer1;

    assign sh_data = grant[1] ? req1_data : req0_data;
    assign sh_amt  = grant[1] ? req1_amt  : req0_amt;
    assign sh_mode = grant[1] ? req1_mode : req0_mode;

    barrel_shifter #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_shifter (
        .data   (sh_data),
        .amt    (sh_amt),
        .mode   (sh_mode),
        .result (sh_result)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_EMPTY: begin
                if (any_xfer) state_nxt = S_FULL;
            end
            S_FULL: begin
                if (any_xfer)       state_nxt = S_FULL;
                else if (rsp_ready) state_nxt = S_EMPTY;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        rsp_valid = 1'b0;
        if (state == S_FULL) rsp_valid = 1'b1;
    end

    // Result payload and last-winner pointer; both move only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            last     <= 1'b1;
        end else if (any_xfer) begin
            rsp_data <= sh_result;
            rsp_id   <= xfer1;
            last     <= xfer1;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - randomized and directed self-checking bench for shift_arbiter

module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_data, req1_data;
    logic [3:0]  req0_amt, req1_amt;
    logic [1:0]  req0_mode, req1_mode;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;

    int n_vec = 0;
    int n_err = 0;

    bit        m_valid = 1'b0;
    bit [15:0] m_data  = 16'h0;
    bit        m_id    = 1'b0;
    bit        m_last  = 1'b1;

`ifdef SHIFT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    shift_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_mode  (req1_mode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    // Bit-by-bit definition of each shift mode.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int amt, input logic [1:0] mode);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            if (mode == 2'b00)      r[i] = (i >= amt) ? d[i - amt] : 1'b0;
            else if (mode == 2'b01) r[i] = (i + amt < 16) ? d[i + amt] : d[15];
            else                    r[i] = d[(i + amt) % 16];
        end
        return r;
    endfunction

    // Which requester the rules say is accepted right now (-1: none).
    function automatic int winner();
        if (rst_n !== 1'b1) return -1;
        if (m_valid && !rsp_ready) return -1;
        if (req0_valid && req1_valid) return (RR && !m_last) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state update.
    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 16'h0;
            m_id    <= 1'b0;
            m_last  <= 1'b1;
        end else begin
            w = winner();
            if (w >= 0) begin
                m_valid <= 1'b1;
                m_id    <= (w == 1);
                m_last  <= (w == 1);
                m_data  <= (w == 1) ? ref_shift(req1_data, int'(req1_amt), req1_mode)
                                    : ref_shift(req0_data, int'(req0_amt), req0_mode);
            end else if (rsp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int w;
        w = winner();
        chk("req0_ready", 32'(req0_ready), 32'(w == 0));
        chk("req1_ready", 32'(req1_ready), 32'(w == 1));
        chk("rsp_valid",  32'(rsp_valid),  32'(m_valid));
        if (m_valid) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_id",   32'(rsp_id),   32'(m_id));
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
        if (n == 0) begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_mode = m;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_mode = m;
        end
    endtask

    task automatic expect_rsp(input string name, input logic [15:0] d, input logic id);
        @(negedge clk);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_data"},  32'(rsp_data),  32'(d));
        chk({name, "_id"},    32'(rsp_id),    32'(id));
        #1;
    endtask

    initial begin
        logic [15:0] held;
        idle();
        req0_data = '0; req0_amt = '0; req0_mode = '0;
        req1_data = '0; req1_amt = '0; req1_mode = '0;
        rsp_ready = 1'b1;

        // Reset state, with a request pending to show readies stay low.
        #1 rst_n = 1'b0;
        set_req(0, 16'h1111, 4'd1, 2'b00);
        #12;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data",  32'(rsp_data),  32'h0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        idle();
        go();
        rst_n = 1'b1;

        // Single requests.
        set_req(0, 16'h00FF, 4'd4, 2'b00); go(); idle(); expect_rsp("sll", 16'h0FF0, 1'b0);
        set_req(1, 16'h8001, 4'd1, 2'b01); go(); idle(); expect_rsp("sra", 16'hC000, 1'b1);
        set_req(0, 16'h1234, 4'd4, 2'b10); go(); idle(); expect_rsp("ror", 16'h4123, 1'b0);
        set_req(0, 16'hAB12, 4'd8, 2'b11); go(); idle(); expect_rsp("ror11", 16'h12AB, 1'b0);
        set_req(1, 16'h8000, 4'd0, 2'b01); go(); idle(); expect_rsp("amt0", 16'h8000, 1'b1);

        // Contention for 4 cycles (last = 1 after the previous req1 transfer).
        set_req(0, 16'h0001, 4'd1, 2'b00);
        set_req(1, 16'h0001, 4'd2, 2'b00);
        for (int k = 0; k < 4; k++) begin
            go();
            expect_rsp("contend", (RR && k % 2 == 1) ? 16'h0004 : 16'h0002,
                       RR ? 1'(k % 2) : 1'b0);
        end
        idle();
        go(); go();

        // Backpressure: fill, then stall 3 cycles with req0 still valid.
        rsp_ready = 1'b0;
        set_req(0, 16'h0001, 4'd1, 2'b00);
        go();
        set_req(0, 16'h0003, 4'd1, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_data",  32'(rsp_data),   32'h0002);
            chk("stall_ready", 32'(req0_ready), 32'd0);
            #1;
            go();
        end
        rsp_ready = 1'b1;
        #1;
        chk("drain_ready", 32'(req0_ready), 32'd1);
        go(); idle();
        expect_rsp("no_bubble", 16'h0006, 1'b0);

        // Reset while holding a stalled result.
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        go();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 16'h0010, 4'd4, 2'b01);
        set_req(1, 16'h0010, 4'd1, 2'b01);
        go(); idle();
        expect_rsp("post_rst", 16'h0001, 1'b0);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (rst_n == 1'b0) rst_n = 1'b1;
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_data  = 16'($urandom); req0_amt = 4'($urandom); req0_mode = 2'($urandom);
            req1_data  = 16'($urandom); req1_amt = 4'($urandom); req1_mode = 2'($urandom);
            rsp_ready  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
            end
        end

        rst_n = 1'b1;
        idle();
        go(); go();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
